// File: rtl/pe_pkg.sv
// ============================================================================
// Module   : pe_pkg
// Brief    : Shared constants, state codes and priority helper for pe_req_capture.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pe_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] state_t;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESENT = 2'd1;
   localparam logic [1:0] GAP     = 2'd2;

   // One-hot of the highest set bit; later (higher) bits overwrite lower ones.
   function automatic logic [NCH-1:0] prio_onehot(input logic [NCH-1:0] v);
      logic [NCH-1:0] r;
      r = '0;
      for (int i = 0; i < NCH; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module   : sync_edge_det
// Brief    : One-channel multi-flop synchronizer with rising-edge or level event.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_edge_det #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_raw,
   output logic evt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_synced;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], req_raw};
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

   generate
      if (EDGE_MODE != 0) begin : g_edge
         logic r_prev;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_prev <= 1'b0;
            end else begin
               r_prev <= w_synced;
            end
         end

         assign evt = w_synced & ~r_prev;
      end else begin : g_level
         assign evt = w_synced;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/pe_req_capture.sv
// ============================================================================
// Module   : pe_req_capture
// Brief    : Captures four async requests as sticky pend bits and presents one
//            stable one-hot request at a time to the priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pe_req_capture
   import pe_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req_in,
   input  logic [NCH-1:0] mask,
   input  logic           ack,
   input  logic           clr_ovr,
   output logic [NCH-1:0] y_out,
   output logic           valid,
   output logic [NCH-1:0] pend,
   output logic [NCH-1:0] ovr
);

   logic [NCH-1:0] w_evt;
   logic [NCH-1:0] w_clr;
   logic [NCH-1:0] w_elig;
   logic [NCH-1:0] w_pend_nxt;
   logic [NCH-1:0] w_ovr_set;

   logic [NCH-1:0] r_pend;
   logic [NCH-1:0] r_ovr;
   logic [NCH-1:0] r_y;
   logic           r_valid;
   state_t         r_state;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         sync_edge_det #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
         ) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_raw (req_in[gi]),
            .evt     (w_evt[gi])
         );
      end
   endgenerate

   always_comb begin
      w_clr  = (r_state == PRESENT && ack) ? r_y : '0;
      w_elig = r_pend & ~mask;
   end

   // A fresh edge on the channel being acked re-arms it instead of flagging overrun.
   generate
      if (EDGE_MODE != 0) begin : g_edge_pend
         assign w_pend_nxt = (r_pend & ~w_clr) | w_evt;
         assign w_ovr_set  = w_evt & r_pend & ~w_clr;
      end else begin : g_level_pend
         assign w_pend_nxt = (r_pend | w_evt) & ~w_clr;
         assign w_ovr_set  = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_ovr  <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_ovr  <= (clr_ovr ? '0 : r_ovr) | w_ovr_set;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_y     <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_elig) begin
                  r_y     <= prio_onehot(w_elig);
                  r_valid <= 1'b1;
                  r_state <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack) begin
                  r_y     <= '0;
                  r_valid <= 1'b0;
                  r_state <= GAP;
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_y     <= '0;
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign y_out = r_y;
   assign valid = r_valid;
   assign pend  = r_pend;
   assign ovr   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_pe_req_capture.sv
// ============================================================================
// Module   : tb_pe_req_capture
// Brief    : Directed plus randomized bench for pe_req_capture with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pe_req_capture;

   localparam int S = 2;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_in;
   logic [3:0] mask;
   logic       ack;
   logic       clr_ovr;
   logic [3:0] y_out;
   logic       valid;
   logic [3:0] pend;
   logic [3:0] ovr;

   int n_chk;
   int n_pass;

   // Reference model: request history, pending/overrun sets, presented request,
   // and number of quiet edges still owed after an ack.
   logic [3:0] m_hist [0:S];
   logic [3:0] m_pend;
   logic [3:0] m_ovr;
   logic [3:0] m_pres;
   int         m_quiet;

   pe_req_capture #(
      .SYNC_STAGES (S),
      .EDGE_MODE   (1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_in  (req_in),
      .mask    (mask),
      .ack     (ack),
      .clr_ovr (clr_ovr),
      .y_out   (y_out),
      .valid   (valid),
      .pend    (pend),
      .ovr     (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] highest(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k <= S; k++) m_hist[k] = 4'b0000;
      m_pend  = 4'b0000;
      m_ovr   = 4'b0000;
      m_pres  = 4'b0000;
      m_quiet = 0;
   endtask

   task automatic model_step();
      logic [3:0] evt;
      logic [3:0] clr;
      logic [3:0] elig;
      if (!rst_n) begin
         model_reset();
         return;
      end
      evt  = m_hist[S-1] & ~m_hist[S];
      clr  = (m_pres != 4'b0000 && ack) ? m_pres : 4'b0000;
      elig = m_pend & ~mask;
      if (m_pres != 4'b0000) begin
         if (ack) begin
            m_pres  = 4'b0000;
            m_quiet = 1;
         end
      end else if (m_quiet > 0) begin
         m_quiet--;
      end else if (elig != 4'b0000) begin
         m_pres = highest(elig);
      end
      m_ovr  = (clr_ovr ? 4'b0000 : m_ovr) | (evt & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | evt;
      for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = req_in;
   endtask

   task automatic check_all();
      chk("y_out",   32'(y_out), 32'(m_pres));
      chk("valid",   32'(valid), 32'(m_pres != 4'b0000));
      chk("pend",    32'(pend),  32'(m_pend));
      chk("ovr",     32'(ovr),   32'(m_ovr));
      chk("onehot0", 32'($onehot0(y_out)), 32'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_valid(input int budget, output int waited);
      waited = 0;
      while (!valid && waited < budget) begin
         tick();
         waited++;
      end
      chk("wait_valid", 32'(valid), 32'd1);
   endtask

   task automatic pulse(input logic [3:0] r);
      req_in = r;
      tick();
      req_in = 4'b0000;
   endtask

   initial begin
      int w;
      n_chk   = 0;
      n_pass  = 0;
      rst_n   = 1'b0;
      req_in  = 4'b0000;
      mask    = 4'b0000;
      ack     = 1'b0;
      clr_ovr = 1'b0;
      model_reset();

      // Reset and idle
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("idle_valid", 32'(valid), 32'd0);

      // Single request: pulse at edge 0, pend after edge 2, present after edge 3
      pulse(4'b0010);
      tick();
      tick();
      chk("single_pend", 32'(pend), 32'b0010);
      chk("single_nvalid", 32'(valid), 32'd0);
      tick();
      chk("single_y", 32'(y_out), 32'b0010);
      repeat (6) tick();
      chk("single_hold", 32'(y_out), 32'b0010);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("single_ack_pend", 32'(pend), 32'b0000);
      chk("single_ack_y", 32'(y_out), 32'b0000);
      repeat (4) tick();

      // Priority order with a GAP+IDLE quiet spacing between presentations
      pulse(4'b1111);
      for (int n = 0; n < 4; n++) begin
         wait_valid(20, w);
         if (n > 0) chk("prio_quiet", 32'(w), 32'd2);
         chk("prio_order", 32'(y_out), 32'(4'b1000 >> n));
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end
      repeat (4) tick();

      // Masking: masked channel waits, unmasking does not withdraw the current one
      mask = 4'b1000;
      pulse(4'b1001);
      wait_valid(20, w);
      chk("mask_first", 32'(y_out), 32'b0001);
      mask = 4'b0000;
      repeat (3) tick();
      chk("mask_hold", 32'(y_out), 32'b0001);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      wait_valid(20, w);
      chk("mask_second", 32'(y_out), 32'b1000);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      repeat (4) tick();

      // Overrun on channel 2, then clr_ovr
      pulse(4'b0100);
      wait_valid(20, w);
      chk("ovr_present", 32'(y_out), 32'b0100);
      pulse(4'b0100);
      repeat (3) tick();
      chk("ovr_set", 32'(ovr), 32'b0100);
      chk("ovr_pend", 32'(pend), 32'b0100);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr_clr", 32'(ovr), 32'b0000);

      // Asynchronous reset while presenting 0100
      chk("rst_pre_y", 32'(y_out), 32'b0100);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_async_y", 32'(y_out), 32'b0000);
      chk("rst_async_valid", 32'(valid), 32'd0);
      chk("rst_async_pend", 32'(pend), 32'b0000);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("rst_no_present", 32'(valid), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         req_in  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 15) == 0) mask = 4'($urandom) & 4'($urandom);
         ack     = valid ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
         clr_ovr = ($urandom_range(0, 19) == 0);
         if (i == 400) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            chk("rnd_async_y", 32'(y_out), 32'b0000);
         end
         if (i == 403) rst_n = 1'b1;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
